// File: rtl/iot_mon_pkg.sv
// rtl/iot_mon_pkg.sv - shared types and width helper for the active-device monitor
package iot_mon_pkg;

   typedef enum logic [0:0] {NORMAL, ALARM} mon_state_t;

   typedef enum logic [1:0] {EV_NONE, EV_APPLY, EV_REDUNDANT, EV_INVALID} ev_class_t;

   // Bits needed to index 'value' distinct items; never returns less than 1.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/mon_alarm_fsm.sv
// rtl/mon_alarm_fsm.sv - hysteresis occupancy alarm driven by the registered device count
module mon_alarm_fsm
   import iot_mon_pkg::*;
#(
   parameter int CNT_W  = 5,
   parameter int HI_THR = 12,
   parameter int LO_THR = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] count,
   output logic             alarm
);

   mon_state_t state_q;
   mon_state_t state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= NORMAL;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = NORMAL;
      end else begin
         case (state_q)
            NORMAL:  if (count >= CNT_W'(HI_THR)) state_d = ALARM;
            ALARM:   if (count <= CNT_W'(LO_THR)) state_d = NORMAL;
            default: state_d = NORMAL;
         endcase
      end
   end

   assign alarm = (state_q == ALARM);

endmodule

// File: rtl/iot_active_monitor_multi.sv
// rtl/iot_active_monitor_multi.sv - per-device presence bitmap, exact active count and alarm
// Optional peak-count register and peak_out port enabled by IOT_MON_PEAK_HOLD_EN.
module iot_active_monitor_multi
   import iot_mon_pkg::*;
#(
   parameter  int N_DEV  = 16,
   parameter  int HI_THR = 12,
   parameter  int LO_THR = 4,
   localparam int ID_W   = clog2_min1(N_DEV),
   localparam int CNT_W  = clog2_min1(N_DEV + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             change,
   input  logic             on_off,
   input  logic [ID_W-1:0]  dev_id,
   input  logic             clear,
   output logic [N_DEV-1:0] active_map,
   output logic [CNT_W-1:0] counter_out,
   output logic             alarm,
   output logic             err_event
`ifdef IOT_MON_PEAK_HOLD_EN
   ,
   output logic [CNT_W-1:0] peak_out
`endif
);

   logic [N_DEV-1:0] map_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   ev_class_t        ev_class;

   // Ids beyond N_DEV only exist for non-power-of-two sizes; they must not touch the map.
   always_comb begin
      ev_class = EV_NONE;
      if (change) begin
         if (32'(dev_id) >= N_DEV)          ev_class = EV_INVALID;
         else if (map_q[dev_id] == on_off)  ev_class = EV_REDUNDANT;
         else                               ev_class = EV_APPLY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         map_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (clear) begin
         map_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= (ev_class == EV_REDUNDANT) || (ev_class == EV_INVALID);
         if (ev_class == EV_APPLY) begin
            map_q[dev_id] <= on_off;
            cnt_q         <= on_off ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
         end
      end
   end

   mon_alarm_fsm #(
      .CNT_W  (CNT_W),
      .HI_THR (HI_THR),
      .LO_THR (LO_THR)
   ) u_alarm (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .count (cnt_q),
      .alarm (alarm)
   );

`ifdef IOT_MON_PEAK_HOLD_EN
   logic [CNT_W-1:0] peak_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 peak_q <= '0;
      else if (clear)           peak_q <= '0;
      else if (cnt_q > peak_q)  peak_q <= cnt_q;
   end

   assign peak_out = peak_q;
`endif

   assign active_map  = map_q;
   assign counter_out = cnt_q;
   assign err_event   = err_q;

endmodule

// File: tb/tb_iot_active_monitor_multi.sv
// tb/tb_iot_active_monitor_multi.sv - self-checking bench with behavioural device-set model
module tb_iot_active_monitor_multi;

   localparam int N   = 16;
   localparam int HI  = 12;
   localparam int LO  = 4;
   localparam int IDW = 4;
   localparam int CW  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          change = 1'b0;
   logic          on_off = 1'b0;
   logic [IDW-1:0] dev_id = '0;
   logic          clear = 1'b0;
   logic [N-1:0]  active_map;
   logic [CW-1:0] counter_out;
   logic          alarm;
   logic          err_event;
`ifdef IOT_MON_PEAK_HOLD_EN
   logic [CW-1:0] peak_out;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   bit m_on[N];
   bit m_alarm;
   bit m_err;
   int m_peak;

   always #5 clk = ~clk;

   iot_active_monitor_multi #(.N_DEV(N), .HI_THR(HI), .LO_THR(LO)) dut (
      .clk         (clk),
      .rst         (rst),
      .change      (change),
      .on_off      (on_off),
      .dev_id      (dev_id),
      .clear       (clear),
      .active_map  (active_map),
      .counter_out (counter_out),
      .alarm       (alarm),
      .err_event   (err_event)
`ifdef IOT_MON_PEAK_HOLD_EN
      ,
      .peak_out    (peak_out)
`endif
   );

   function automatic int mcount();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_on[i]) c++;
      return c;
   endfunction

   function automatic logic [N-1:0] mmap();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_on[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_on[i] = 1'b0;
      m_alarm = 1'b0;
      m_err   = 1'b0;
      m_peak  = 0;
   endtask

   // One clock of stimulus: drive, take the edge, advance the model by the same rules.
   task automatic step(input bit c, input bit oo, input int id, input bit clr);
      int old_cnt;
      change = c;
      on_off = oo;
      dev_id = IDW'(id);
      clear  = clr;
      @(posedge clk);
      #1;
      old_cnt = mcount();
      if (clr) begin
         model_reset();
      end else begin
         if (!m_alarm && old_cnt >= HI) m_alarm = 1'b1;
         else if (m_alarm && old_cnt <= LO) m_alarm = 1'b0;
         if (old_cnt > m_peak) m_peak = old_cnt;
         m_err = 1'b0;
         if (c) begin
            if (id >= N)           m_err = 1'b1;
            else if (m_on[id] == oo) m_err = 1'b1;
            else                   m_on[id] = oo;
         end
      end
      change = 1'b0;
      clear  = 1'b0;
      n_cmp++;
      if (int'(counter_out) != $countones(active_map)) begin
         n_fail++;
         $display("FAIL invariant t=%0t counter_out=%0d popcount=%0d", $time, counter_out, $countones(active_map));
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 5; k++) begin
         change = 1'($urandom);
         on_off = 1'b1;
         dev_id = IDW'($urandom);
         @(posedge clk);
         #1;
         n_cmp++;
         if ({active_map, counter_out, alarm, err_event} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d map=%h cnt=%0d alarm=%b err=%b want all 0", k, active_map, counter_out, alarm, err_event);
         end
      end
      change = 1'b0;
      rst    = 1'b1;
      model_reset();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, i, 1'b0);
         n_cmp++;
         if (counter_out !== CW'(i + 1) || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL fill dev=%0d cnt=%0d alarm=%b want cnt=%0d alarm=0", i, counter_out, alarm, i + 1);
         end
      end
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (alarm !== 1'b1 || alarm !== m_alarm) begin
         n_fail++;
         $display("FAIL fill_alarm alarm=%b want 1", alarm);
      end
   endtask

   task automatic test_drain();
      for (int i = 11; i >= 4; i--) begin
         step(1'b1, 1'b0, i, 1'b0);
         n_cmp++;
         if (counter_out !== CW'(i) || alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL drain dev=%0d cnt=%0d alarm=%b want cnt=%0d alarm=1", i, counter_out, alarm, i);
         end
      end
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (alarm !== 1'b0 || alarm !== m_alarm) begin
         n_fail++;
         $display("FAIL drain_alarm alarm=%b want 0", alarm);
      end
   endtask

   task automatic test_redundant();
      step(1'b1, 1'b1, 12, 1'b0);
      n_cmp++;
      if (counter_out !== CW'(5) || err_event !== 1'b0) begin
         n_fail++;
         $display("FAIL redund_first cnt=%0d err=%b want cnt=5 err=0", counter_out, err_event);
      end
      step(1'b1, 1'b1, 12, 1'b0);
      n_cmp++;
      if (counter_out !== CW'(5) || err_event !== 1'b1) begin
         n_fail++;
         $display("FAIL redund_on cnt=%0d err=%b want cnt=5 err=1", counter_out, err_event);
      end
      step(1'b1, 1'b0, 15, 1'b0);
      n_cmp++;
      if (counter_out !== CW'(5) || err_event !== 1'b1 || active_map !== mmap()) begin
         n_fail++;
         $display("FAIL redund_off cnt=%0d err=%b map=%h want cnt=5 err=1 map=%h", counter_out, err_event, active_map, mmap());
      end
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (err_event !== 1'b0) begin
         n_fail++;
         $display("FAIL redund_pulse err=%b want 0", err_event);
      end
   endtask

   task automatic test_clear_with_change();
      int devs[7] = '{4, 5, 6, 8, 9, 10, 11};
      foreach (devs[k]) step(1'b1, 1'b1, devs[k], 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (alarm !== 1'b1 || counter_out !== CW'(12)) begin
         n_fail++;
         $display("FAIL clear_setup alarm=%b cnt=%0d want alarm=1 cnt=12", alarm, counter_out);
      end
      step(1'b1, 1'b1, 7, 1'b1);
      n_cmp++;
      if (active_map !== '0 || counter_out !== '0 || alarm !== 1'b0 || err_event !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_change map=%h cnt=%0d alarm=%b err=%b want all 0", active_map, counter_out, alarm, err_event);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         int  bias = ((k / 50) % 2 == 0) ? 80 : 20;
         bit  oo   = ($urandom_range(99) < bias);
         bit  c    = ($urandom_range(3) != 0);
         bit  clr  = ($urandom_range(63) == 0);
         step(c, oo, int'($urandom_range(N - 1)), clr);
         n_cmp++;
         if (active_map !== mmap() || counter_out !== CW'(mcount()) || alarm !== m_alarm || err_event !== m_err) begin
            n_fail++;
            $display("FAIL random cyc=%0d map=%h cnt=%0d alarm=%b err=%b want map=%h cnt=%0d alarm=%b err=%b",
                     k, active_map, counter_out, alarm, err_event, mmap(), mcount(), m_alarm, m_err);
         end
`ifdef IOT_MON_PEAK_HOLD_EN
         n_cmp++;
         if (peak_out !== CW'(m_peak)) begin
            n_fail++;
            $display("FAIL random_peak cyc=%0d peak=%0d want %0d", k, peak_out, m_peak);
         end
`endif
      end
   endtask

`ifdef IOT_MON_PEAK_HOLD_EN
   task automatic test_peak();
      step(1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, i, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      for (int i = 11; i >= 4; i--) step(1'b1, 1'b0, i, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (peak_out !== CW'(12) || counter_out !== CW'(4)) begin
         n_fail++;
         $display("FAIL peak_hold peak=%0d cnt=%0d want peak=12 cnt=4", peak_out, counter_out);
      end
      step(1'b0, 1'b0, 0, 1'b1);
      n_cmp++;
      if (peak_out !== '0) begin
         n_fail++;
         $display("FAIL peak_clear peak=%0d want 0", peak_out);
      end
   endtask
`endif

   task automatic test_async_reset();
      step(1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (counter_out !== CW'(9)) begin
         n_fail++;
         $display("FAIL async_setup cnt=%0d want 9", counter_out);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({active_map, counter_out, alarm, err_event} !== '0) begin
         n_fail++;
         $display("FAIL async_reset map=%h cnt=%0d alarm=%b err=%b want all 0", active_map, counter_out, alarm, err_event);
      end
`ifdef IOT_MON_PEAK_HOLD_EN
      n_cmp++;
      if (peak_out !== '0) begin
         n_fail++;
         $display("FAIL async_peak peak=%0d want 0", peak_out);
      end
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      step(1'b1, 1'b1, 5, 1'b0);
      n_cmp++;
      if (counter_out !== CW'(1) || active_map !== 16'h0020) begin
         n_fail++;
         $display("FAIL async_restart cnt=%0d map=%h want cnt=1 map=0020", counter_out, active_map);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_drain();
      test_redundant();
      test_clear_with_change();
      test_random();
`ifdef IOT_MON_PEAK_HOLD_EN
      test_peak();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
